// File: rtl/oc8051_ifetch_pkg.sv
// Shared types and helpers for the oc8051 instruction fetch stage:
// FSM state encoding, reset constants and the opcode-length table.
package oc8051_ifetch_pkg;

    typedef enum logic [2:0] {
        ST_ADDR  = 3'd0,
        ST_DATA  = 3'd1,
        ST_EXT   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } ifetch_state_e;

    localparam int          INT_ROM_WID_DEF = 7;
    localparam logic [15:0] RST_PC_DEF      = 16'h0000;
    localparam logic [1:0]  RST_LEN         = 2'd1;

    // Instruction length in bytes (1..3) for every 8051 opcode, grouped
    // by the low nibble, which selects the addressing-mode column.
    function automatic logic [1:0] LEN(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi  = op[7:4];
        lo  = op[3:0];
        LEN = 2'd1;
        if (lo == 4'h1) begin
            // AJMP / ACALL page-relative forms
            LEN = 2'd2;
        end else if (lo >= 4'h8) begin
            // Rn register forms
            case (hi)
                4'h7, 4'h8, 4'hA, 4'hD: LEN = 2'd2;
                4'hB:                   LEN = 2'd3;
                default:                LEN = 2'd1;
            endcase
        end else if (lo >= 4'h6) begin
            // @Ri indirect forms
            case (hi)
                4'h7, 4'h8, 4'hA: LEN = 2'd2;
                4'hB:             LEN = 2'd3;
                default:          LEN = 2'd1;
            endcase
        end else begin
            case (lo)
                4'h0: begin
                    case (hi)
                        4'h1, 4'h2, 4'h3, 4'h9: LEN = 2'd3;
                        4'h0, 4'hE, 4'hF:       LEN = 2'd1;
                        default:                LEN = 2'd2;
                    endcase
                end
                4'h2: begin
                    case (hi)
                        4'h0, 4'h1:             LEN = 2'd3;
                        4'h2, 4'h3, 4'hE, 4'hF: LEN = 2'd1;
                        default:                LEN = 2'd2;
                    endcase
                end
                4'h3: begin
                    case (hi)
                        4'h4, 4'h5, 4'h6: LEN = 2'd3;
                        default:          LEN = 2'd1;
                    endcase
                end
                4'h4: begin
                    case (hi)
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: LEN = 2'd2;
                        4'hB:                                     LEN = 2'd3;
                        default:                                  LEN = 2'd1;
                    endcase
                end
                4'h5: begin
                    case (hi)
                        4'h7, 4'h8, 4'hB, 4'hD: LEN = 2'd3;
                        4'hA:                   LEN = 2'd1;
                        default:                LEN = 2'd2;
                    endcase
                end
                default: LEN = 2'd1;
            endcase
        end
    endfunction

endpackage

// File: rtl/oc8051_ifetch.sv
// oc8051 instruction fetch: reads opcode plus operands from internal ROM
// (three registered bytes) or byte-by-byte from the external program port,
// and presents one whole instruction to the decoder.
// Handshake: ins_* is presented with ins_valid and held unchanged until a
// cycle where ins_valid & ins_ready is seen at the rising edge; ext_req is
// held with a stable ext_addr until ext_ack is seen with it.
module oc8051_ifetch
    import oc8051_ifetch_pkg::*;
#(
    parameter int          INT_ROM_WID = INT_ROM_WID_DEF,
    parameter logic [15:0] RST_PC      = RST_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic [15:0] ext_addr,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data,
    input  logic        jmp_valid,
    input  logic [15:0] jmp_addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  ins_op1,
    output logic [7:0]  ins_op2,
    output logic [7:0]  ins_op3,
    output logic [1:0]  ins_len,
    output logic [15:0] ins_pc
);

    ifetch_state_e state_q;
    logic [15:0]   pc_q;
    logic [15:0]   jmp_tgt_q;
    logic [15:0]   ext_addr_q;
    logic [15:0]   ins_pc_q;
    logic [1:0]    byte_idx_q;
    logic [1:0]    ins_len_q;
    logic [7:0]    op1_q;
    logic [7:0]    op2_q;
    logic [7:0]    op3_q;
    logic          ins_valid_q;
    logic          ext_req_q;

    logic          addr_is_int_d;
    logic [1:0]    rom_len_d;
    logic [1:0]    ext_len_d;
    logic          ext_last_d;
    logic          ext_hit_d;
    logic [15:0]   pc_seq_d;

    // The first-byte address picks the source for the whole instruction;
    // the address range check backs up the ROM's own indication.
    assign addr_is_int_d = rom_ea_int && ((pc_q >> INT_ROM_WID) == 16'd0);
    assign rom_len_d     = LEN(rom_data1);
    assign ext_len_d     = (byte_idx_q == 2'd0) ? LEN(ext_data) : ins_len_q;
    assign ext_last_d    = ((byte_idx_q + 2'd1) == ext_len_d);
    assign ext_hit_d     = ext_req_q & ext_ack;
    assign pc_seq_d      = pc_q + {14'd0, ins_len_q};

    assign rom_addr  = pc_q;
    assign ext_addr  = ext_addr_q;
    assign ext_req   = ext_req_q;
    assign ins_valid = ins_valid_q;
    assign ins_op1   = op1_q;
    assign ins_op2   = op2_q;
    assign ins_op3   = op3_q;
    assign ins_len   = ins_len_q;
    assign ins_pc    = ins_pc_q;

    // Fetch FSM: sequences ROM/external reads, instruction hand-off and redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ADDR;
            pc_q        <= RST_PC;
            jmp_tgt_q   <= 16'h0000;
            ext_addr_q  <= 16'h0000;
            ins_pc_q    <= RST_PC;
            byte_idx_q  <= 2'd0;
            ins_len_q   <= RST_LEN;
            op1_q       <= 8'h00;
            op2_q       <= 8'h00;
            op3_q       <= 8'h00;
            ins_valid_q <= 1'b0;
            ext_req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (jmp_valid) begin
                        pc_q <= jmp_addr;
                    end else if (addr_is_int_d) begin
                        state_q <= ST_DATA;
                    end else begin
                        ext_addr_q <= pc_q;
                        byte_idx_q <= 2'd0;
                        ext_req_q  <= 1'b1;
                        state_q    <= ST_EXT;
                    end
                end
                ST_DATA: begin
                    if (jmp_valid) begin
                        pc_q    <= jmp_addr;
                        state_q <= ST_ADDR;
                    end else begin
                        op1_q       <= rom_data1;
                        op2_q       <= (rom_len_d >= 2'd2) ? rom_data2 : 8'h00;
                        op3_q       <= (rom_len_d == 2'd3) ? rom_data3 : 8'h00;
                        ins_len_q   <= rom_len_d;
                        ins_pc_q    <= pc_q;
                        ins_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_EXT: begin
                    if (jmp_valid) begin
                        // Only an outstanding, not-yet-acked request needs draining.
                        if (ext_req_q && !ext_ack) begin
                            jmp_tgt_q <= jmp_addr;
                            state_q   <= ST_DRAIN;
                        end else begin
                            ext_req_q <= 1'b0;
                            pc_q      <= jmp_addr;
                            state_q   <= ST_ADDR;
                        end
                    end else if (ext_hit_d) begin
                        ext_req_q <= 1'b0;
                        case (byte_idx_q)
                            2'd0: begin
                                op1_q     <= ext_data;
                                op2_q     <= 8'h00;
                                op3_q     <= 8'h00;
                                ins_len_q <= ext_len_d;
                                ins_pc_q  <= pc_q;
                            end
                            2'd1:    op2_q <= ext_data;
                            default: op3_q <= ext_data;
                        endcase
                        if (ext_last_d) begin
                            ins_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            ext_addr_q <= ext_addr_q + 16'd1;
                        end
                    end else if (!ext_req_q) begin
                        // Idle cycle after an ack: request the next byte.
                        ext_req_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (jmp_valid) begin
                        pc_q        <= jmp_addr;
                        ins_valid_q <= 1'b0;
                        state_q     <= ST_ADDR;
                    end else if (ins_ready) begin
                        pc_q        <= pc_seq_d;
                        ins_valid_q <= 1'b0;
                        state_q     <= ST_ADDR;
                    end
                end
                ST_DRAIN: begin
                    if (jmp_valid) begin
                        jmp_tgt_q <= jmp_addr;
                    end
                    if (ext_hit_d) begin
                        ext_req_q <= 1'b0;
                        pc_q      <= jmp_valid ? jmp_addr : jmp_tgt_q;
                        state_q   <= ST_ADDR;
                    end
                end
                default: begin
                    state_q <= ST_ADDR;
                end
            endcase
        end
    end

endmodule

// File: doc/oc8051_ifetch.md
# oc8051_ifetch

Instruction fetch stage of the oc8051 core, sitting directly downstream of `oc8051_rom`. It drives the fetch address and captures the three registered ROM bytes, or collects bytes from an external program-memory port when the address is outside internal ROM. It decodes the instruction length and presents one complete instruction (opcode plus up to two operands) to the decoder through a valid/ready handshake. It also accepts PC redirects for jumps.

## Interface
- `INT_ROM_WID`, 7: addresses with any of bits [15:INT_ROM_WID] set are external.
- `RST_PC`, 16'h0000: PC loaded on reset.

Ports (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `rom_addr` out 16: fetch address to `oc8051_rom`.
- `rom_ea_int` in 1: 1 means `rom_addr` is in internal ROM.
- `rom_data1`, `rom_data2`, `rom_data3` in 8: ROM bytes at addr, +1, +2; valid in the cycle after `rom_addr` is sampled.
- `ext_addr` out 16: external byte address.
- `ext_req` out 1: external read request.
- `ext_ack` in 1: external byte valid.
- `ext_data` in 8: external byte.
- `jmp_valid` in 1: redirect request.
- `jmp_addr` in 16: redirect target.
- `ins_valid` out 1: instruction available.
- `ins_ready` in 1: decoder accepts.
- `ins_op1`, `ins_op2`, `ins_op3` out 8: opcode and operands; unused bytes are 0.
- `ins_len` out 2: instruction length, 1..3.
- `ins_pc` out 16: address of `ins_op1`.

## Operation
- States: ADDR, DATA, EXT, HOLD, DRAIN.
- **ADDR:** `rom_addr` = pc.
  - If `rom_ea_int` = 1, go to DATA.
  - Otherwise load `ext_addr` = pc, set byte index = 0, go to EXT.
- **DATA:** latch `rom_data1..3` into op1..3. Latch len = `LEN(rom_data1)` and ins_pc = pc. Zero the bytes beyond len. Go to HOLD.
- **EXT:**
  - Hold `ext_req` high until `ext_ack`. On ack, store `ext_data` at the current byte index.
  - After byte 0, len = `LEN(byte0)`.
  - If more bytes are needed, `ext_addr` += 1 and re-assert `ext_req` the following cycle. Otherwise go to HOLD.
  - Every byte of an instruction comes from the source selected by its first-byte address, even when the instruction straddles the boundary.
- **HOLD:** `ins_valid` = 1. On `ins_valid` & `ins_ready`, pc <= pc + len (16-bit, wraps FFFF to 0000) and go to ADDR.
- **Jump handling:**
  - `jmp_valid` in ADDR, DATA or HOLD: pc <= `jmp_addr`, go to ADDR, `ins_valid` = 0 next cycle. The jump wins over a simultaneous handshake; that handshake still counts as consumed.
  - `jmp_valid` in EXT: record the target and go to DRAIN. DRAIN keeps `ext_req` until `ext_ack`, discards the byte, then goes to ADDR with pc = the recorded target. A later `jmp_valid` overwrites the recorded target.
- **Reset:** state = ADDR, pc = `RST_PC`, `ins_valid` = 0, `ext_req` = 0, `ins_op1..3` = 0, `ins_len` = 1, `ins_pc` = `RST_PC`, `ext_addr` = 0. `rom_addr` follows pc, so it reads `RST_PC`. Reset mid-transaction abandons it immediately; the external port must tolerate a dropped `ext_req`.

## Timing
- Internal path: entering ADDR to `ins_valid` high takes 2 cycles. With `ins_ready` held high, throughput is 1 instruction per 3 cycles.
- External path: `ext_req` rises 1 cycle after ADDR. `ins_valid` rises the cycle after the last `ext_ack`. There is one idle cycle between byte requests.
- `ins_*` outputs are registered and stay stable while `ins_valid` & !`ins_ready`.
- `ext_addr` stays stable while `ext_req` is high.
- `ext_ack` without `ext_req` is ignored.

## Structure
- Package `oc8051_ifetch_pkg` holds:
  - state enum;
  - `LEN` function, the 8051 opcode-to-length table covering all 256 opcodes (e.g. 00 gives 1, E4 gives 1, 78 gives 2, 80 gives 2, 02 gives 3, 75 gives 3, 85 gives 3);
  - reset constants.
- No sub-module needed; `LEN` stays a package function.

## Test plan
- Reset with `RST_PC` = 0, ROM image 02 00 25 at 0000: `rom_addr` = 0000 and `ins_valid` = 0 during reset. After release, `ins_valid` is high in the 2nd cycle with op 02/00/25, len 3, pc 0000.
- Accept that instruction, then assert `jmp_valid` to 0025 where the ROM holds 78 7F E4: get len 2, op 78/7F/00, pc 0025. The next fetch is E4 (len 1) at 0027.
- Back-pressure: hold `ins_ready` low for 5 cycles in HOLD. Outputs stay unchanged and `rom_addr` does not advance. Release: pc advances by exactly len.
- External fetch at 0080 with `rom_ea_int` = 0 and bytes 75 81 07, each acked after a 0–3 cycle random delay: `ext_addr` reads 0080/0081/0082 and the result is len 3, op 75/81/07.
- `jmp_valid` to 0003 while `ext_req` is pending: the acked byte is discarded and no `ins_valid` occurs. The next fetch address is 0003.
- pc = FFFF, external 1-byte NOP (00), accepted: the next fetch is at 0000 via internal ROM.
